// File: rtl/fxp_add_arbiter.sv
// Shared sign-magnitude saturating adder behind a round-robin arbiter.
// One operation is in flight at a time: IDLE (grant) -> CALC (add) -> DONE (hold result).

module fxp_sm_add #(
    parameter int BITSIZE = 16
) (
    input  logic [BITSIZE-1:0] i_a,
    input  logic [BITSIZE-1:0] i_b,
    output logic [BITSIZE-1:0] o_sum
);
    localparam int MW = BITSIZE - 1;

    logic          w_sa, w_sb;
    logic [MW-1:0] w_ma, w_mb;
    logic [MW:0]   w_add;

    assign w_sa  = i_a[BITSIZE-1];
    assign w_sb  = i_b[BITSIZE-1];
    assign w_ma  = i_a[MW-1:0];
    assign w_mb  = i_b[MW-1:0];
    assign w_add = {1'b0, w_ma} + {1'b0, w_mb};

    // A magnitude tie takes the sign of B, so -0 can come out; it is not normalised.
    always_comb begin
        o_sum = '0;
        if (w_sa == w_sb)
            o_sum = {w_sa, (w_add[MW] ? {MW{1'b1}} : w_add[MW-1:0])};
        else if (w_ma > w_mb)
            o_sum = {w_sa, w_ma - w_mb};
        else
            o_sum = {w_sb, w_mb - w_ma};
    end
endmodule

module fxp_add_arbiter #(
    parameter int BITSIZE = 16,
    parameter int NREQ    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*BITSIZE-1:0]     req_a,
    input  logic [NREQ*BITSIZE-1:0]     req_b,
    output logic [NREQ-1:0]             req_ready,
    output logic                        res_valid,
    output logic [BITSIZE-1:0]          res_data,
    output logic [$clog2(NREQ)-1:0]     res_id,
    input  logic                        res_ready
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [IW-1:0]        r_ptr;
    logic [BITSIZE-1:0]   r_op_a, r_op_b;
    logic [IW-1:0]        r_op_id;
    logic [BITSIZE-1:0]   r_res_data;
    logic [IW-1:0]        r_res_id;

    logic                 w_any;
    logic [IW-1:0]        w_win;
    logic                 w_accept;
    logic [IW-1:0]        w_ptr_nxt;
    logic [BITSIZE-1:0]   w_sum;

    // Walk the ring from the highest offset down so the first valid in
    // search order (ptr, ptr+1, ...) is the last one written and wins.
    always_comb begin
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                w_any = 1'b1;
                w_win = IW'(idx);
            end
        end
    end

    assign w_accept  = (r_state == S_IDLE) && w_any && !rst;
    assign w_ptr_nxt = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
    assign req_ready = w_accept ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
            S_CALC:  w_state_nxt = S_DONE;
            S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    fxp_sm_add #(.BITSIZE(BITSIZE)) u_add (
        .i_a   (r_op_a),
        .i_b   (r_op_b),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_id    <= '0;
            r_res_data <= '0;
            r_res_id   <= '0;
        end else begin
            if (w_accept) begin
                r_ptr   <= w_ptr_nxt;
                r_op_a  <= req_a[int'(w_win)*BITSIZE +: BITSIZE];
                r_op_b  <= req_b[int'(w_win)*BITSIZE +: BITSIZE];
                r_op_id <= w_win;
            end
            if (r_state == S_CALC) begin
                r_res_data <= w_sum;
                r_res_id   <= r_op_id;
            end
        end
    end

    assign res_valid = (r_state == S_DONE);
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
endmodule

// File: tb/tb_fxp_add_arbiter.sv
// Directed bench for fxp_add_arbiter: inputs change and outputs are sampled on the falling edge.

module tb_fxp_add_arbiter;
    localparam int BITSIZE = 16;
    localparam int NREQ    = 4;

    logic                    clk;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*BITSIZE-1:0] req_a;
    logic [NREQ*BITSIZE-1:0] req_b;
    logic [NREQ-1:0]         req_ready;
    logic                    res_valid;
    logic [BITSIZE-1:0]      res_data;
    logic [1:0]              res_id;
    logic                    res_ready;

    int n_checks = 0;
    int n_fail   = 0;

    fxp_add_arbiter #(.BITSIZE(BITSIZE), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_checks++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        n_checks++;
        if (res_data !== 16'h0000 || res_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_res: got %h/%0d want 0000/0", res_data, res_id);
        end
        req_valid = '0; rst = 1'b0; res_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        req_valid = 4'b0001; req_a[15:0] = 16'h0005; req_b[15:0] = 16'h0003;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL basic_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_calc: ready %b valid %b want 0000 0", req_ready, res_valid);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0008 || res_id !== 2'd0) begin
            n_fail++; $display("FAIL basic_result: got v%b %h id%0d want v1 0008 id0", res_valid, res_data, res_id);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || res_data !== 16'h0008 || res_id !== 2'd0) begin
            n_fail++; $display("FAIL basic_hold_after: got v%b %h id%0d want v0 0008 id0", res_valid, res_data, res_id);
        end
    endtask

    task automatic test_sign_sat();
        logic [15:0] va [4] = '{16'h8010, 16'h0004, 16'h7FFF, 16'hC000};
        logic [15:0] vb [4] = '{16'h0004, 16'h8004, 16'h0001, 16'hC000};
        logic [15:0] ve [4] = '{16'h800C, 16'h8000, 16'h7FFF, 16'hFFFF};
        logic [3:0]  oh;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            req_valid = oh;
            req_a[k*16 +: 16] = va[k];
            req_b[k*16 +: 16] = vb[k];
            #1;
            n_checks++;
            if (req_ready !== oh) begin n_fail++; $display("FAIL sat_grant%0d: got %b want %b", k, req_ready, oh); end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== ve[k] || res_id !== 2'(k)) begin
                n_fail++;
                $display("FAIL sat_result%0d: got v%b %h id%0d want v1 %h id%0d", k, res_valid, res_data, res_id, ve[k], k);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        logic [3:0]  oh;
        logic [15:0] ed;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = 16'(i + 1);
            req_b[i*16 +: 16] = 16'h0010;
        end
        req_valid = 4'b1111; res_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << exp_id[g];
            ed = 16'h0011 + 16'(exp_id[g]);
            #1;
            n_checks++;
            if (req_ready !== oh) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, oh); end
            @(negedge clk);
            n_checks++;
            if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_calc_ready%0d: got %b want 0000", g, req_ready); end
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_id !== 2'(exp_id[g]) || res_data !== ed) begin
                n_fail++;
                $display("FAIL rr_result%0d: got v%b %h id%0d want v1 %h id%0d", g, res_valid, res_data, res_id, ed, exp_id[g]);
            end
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        // ptr is 1 after the round-robin run; only requester 2 asks first.
        res_ready = 1'b0;
        req_valid = 4'b0100;
        req_a[32 +: 16] = 16'h0100; req_b[32 +: 16] = 16'h8001;
        req_a[16 +: 16] = 16'h0000; req_b[16 +: 16] = 16'h0000;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0110;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 16'h00FF || res_id !== 2'd2 || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v%b %h id%0d rdy%b want v1 00ff id2 rdy0000", c, res_valid, res_data, res_id, req_ready);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_same_cycle: got %b want 0000", req_ready); end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_next_grant: got v%b rdy%b want v0 rdy0010", res_valid, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 16'h0000) begin
            n_fail++; $display("FAIL bp_second: got v%b %h id%0d want v1 0000 id1", res_valid, res_data, res_id);
        end
        @(negedge clk);
    endtask

    task automatic test_isolation();
        req_valid = 4'b1000;
        req_a[48 +: 16] = 16'h0020; req_b[48 +: 16] = 16'h0022;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL iso_grant: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        req_a[48 +: 16] = 16'h7FFF; req_b[48 +: 16] = 16'h7FFF;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0042 || res_id !== 2'd3) begin
            n_fail++; $display("FAIL iso_result: got v%b %h id%0d want v1 0042 id3", res_valid, res_data, res_id);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        // ptr is 0 here; granting requester 1 moves it to 2.
        req_valid = 4'b0010;
        req_a[16 +: 16] = 16'h0003; req_b[16 +: 16] = 16'h0003;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_grant: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || res_data !== 16'h0000 || res_id !== 2'd0 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rmid_reset_vals: got v%b %h id%0d rdy%b want v0 0000 id0 rdy0000", res_valid, res_data, res_id, req_ready);
        end
        rst = 1'b0;
        req_valid = 4'b0101;
        req_a[0 +: 16] = 16'h0001; req_b[0 +: 16] = 16'h0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ptr: got rdy%b v%b want rdy0001 v0", req_ready, res_valid);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0002 || res_id !== 2'd0) begin
            n_fail++; $display("FAIL rmid_after: got v%b %h id%0d want v1 0002 id0", res_valid, res_data, res_id);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_sign_sat();
        test_round_robin();
        test_back_pressure();
        test_isolation();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fxp_add_arbiter.md
# fxp_add_arbiter

Shares one sign-magnitude saturating fixed-point adder among NREQ requesters. Requesters present operand pairs with a valid/ready handshake. A round-robin arbiter grants one request at a time, and the operands are registered before the add. The result is returned on a single output channel, tagged with the requester index and held until the consumer accepts it. The block sits between the datapath stages that issue additions and the shared adder resource.

## Interface
- BITSIZE, 16: operand/result width; MSB is the sign, BITSIZE-1 LSBs are the magnitude.
- NREQ, 4: number of requesters, 2..8.
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- req_valid  in  NREQ: bit i means requester i has an operand pair.
- req_a  in  NREQ*BITSIZE: operand A of requester i in bits [i*BITSIZE +: BITSIZE].
- req_b  in  NREQ*BITSIZE: operand B, same packing.
- req_ready  out  NREQ: one-hot or zero; bit i high means requester i is accepted this cycle.
- res_valid  out  1: result available.
- res_data  out  BITSIZE: sign-magnitude sum.
- res_id  out  $clog2(NREQ): index of the requester that owns res_data.
- res_ready  in  1: consumer accepts the result.

## Operation
- FSM states and transitions:
  - IDLE -> CALC on accept.
  - CALC -> DONE unconditionally.
  - DONE -> IDLE when res_ready=1, otherwise stay in DONE.
- Accept: occurs in IDLE when any req_valid is high.
  - req_ready drives one-hot the bit of the winner; the handshake completes the same cycle.
  - req_ready is 0 in CALC and DONE, and while rst=1.
- Arbitration is round-robin with pointer ptr.
  - Search order is ptr, ptr+1, … NREQ-1, 0, … ptr-1.
  - The first valid requester wins.
  - On accept, ptr <= winner+1 (mod NREQ).
  - ptr resets to 0, so requester 0 has top priority after reset.
- On accept, the winner's A, B and index are latched into op_a, op_b and op_id. Later changes on req_* have no effect.
- Arithmetic in CALC uses sA/sB (sign bits) and mA/mB (magnitudes, BITSIZE-1 bits):
  - Signs equal: sum = mA+mB, computed in BITSIZE bits. If the carry bit is set, the magnitude saturates to all ones; otherwise it is the sum. Result sign is sA.
  - Signs differ and mA>mB: magnitude is mA-mB, sign is sA.
  - Signs differ and mA<=mB: magnitude is mB-mA, sign is sB. A tie therefore gives magnitude 0 with sign sB, which can be negative zero. Negative zero is passed through unmodified.
- The CALC result is registered into res_data, and res_id is set to op_id, on the CALC->DONE edge.
- res_valid=1 exactly while in DONE. res_data and res_id stay stable in DONE until the handshake.
- After the res_ready handshake, res_data and res_id keep their last values; only res_valid drops.

## Timing
- Reset values: state IDLE, ptr 0, res_valid 0, res_data 0, res_id 0, req_ready 0.
- Latency: an accept at edge N gives res_valid=1 in the cycle after edge N+2. This is 2 cycles from the accept to result visibility.
- Throughput: one operation per 3 cycles when res_ready is held high.
- Each extra cycle of res_ready=0 adds one cycle.
- A new accept is possible in the cycle after the res handshake; it is never possible in the same cycle.
- Requesters may raise or drop req_valid at any time. A dropped request that was not granted is simply not served.
- rst=1 in any state aborts an in-flight operation with no result produced; all reset values apply on the next edge.
- With no requests pending, the FSM stays in IDLE and ptr is unchanged.

## Test plan
- Basic add: BITSIZE=16, req 0 with A=0x0005, B=0x0003 -> req_ready[0]=1 for one cycle; 2 cycles later res_valid=1, res_data=0x0008, res_id=0.
- Sign and saturation:
  - A=0x8010, B=0x0004 -> 0x800C.
  - A=0x0004, B=0x8004 -> 0x8000 (negative zero).
  - A=0x7FFF, B=0x0001 -> 0x7FFF.
  - A=0xC000, B=0xC000 -> 0xFFFF.
- Round-robin: all 4 req_valid held high, res_ready=1 -> grants in order 0,1,2,3,0, each 3 cycles apart; res_id follows the same order.
- Back-pressure: res_ready=0 for 5 cycles in DONE -> res_valid, res_data and res_id stay stable, req_ready stays 0; on res_ready=1, IDLE is reached and the next grant comes one cycle later.
- Operand isolation: change req_a/req_b the cycle after accept -> the result uses the latched values.
- Reset mid-op: assert rst in CALC -> no res_valid; the next edge has all reset values; after release, requester 0 wins even if ptr was 2.
